logic_sweep_ctrl: RTL and testbench
===================================

// Module: logic_sweep_ctrl
// PURPOSE
//  Sequencer for the exp-4 gate-level functions. Sweeps {a,b,c,d} through all 16 codes.
//  After each vector it waits a settle time, captures the DUT outputs f,g,h and checks them
//  against internal golden equations. Each result goes out on a valid/ready log port.
//  Sits between the combinational blocks under test and a logger/LED front end.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles a vector is held before f,g,h are sampled (legal >=1, <=255)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   begin sweep; sampled only in IDLE
//  abort      in   1   stop sweep, return to IDLE
//  a,b,c,d    out  1   vector driven to DUTs; vec[3:0]={a,b,c,d}
//  f,g,h      in   1   DUT outputs (f=part1, g=part3, h=part5)
//  res_valid  out  1   result record available
//  res_ready  in   1   consumer accepts record
//  res_vec    out  4   vector of current record
//  res_got    out  3   sampled {f,g,h}
//  res_exp    out  3   golden {f,g,h}
//  res_err    out  1   res_got != res_exp
//  busy       out  1   high in any state but IDLE
//  done       out  1   one-cycle pulse at sweep completion
//  pass       out  1   err_count==0 at last completed sweep; held until next start
//  err_count  out  5   mismatching vectors this sweep (0..16)
//  fail_mask  out  16  bit i set if vector i mismatched
// BEHAVIOUR
//  Reset: state IDLE; a..d=0, all res_*=0, res_valid=0, busy=0, done=0, pass=0,
//   err_count=0, fail_mask=0, settle counter=0. Reset mid-sweep discards all progress.
//  Golden: f=a^b; g=ab|ac|b&~c; h=d|(c&~(a&b)).
//  FSM IDLE -> SETTLE -> REPORT -> (SETTLE | DONE) -> IDLE:
//   IDLE: start=1 & abort=0 -> vec=0, cnt=0, err_count=0, fail_mask=0, pass=0, go SETTLE.
//   SETTLE: vec held on a..d; cnt++ each cycle. At cnt==SETTLE_CYCLES-1: latch f,g,h
//    into res_got, golden into res_exp, set res_err. On mismatch: err_count++ and
//    fail_mask[vec]=1. Go REPORT. The sample is taken on the SETTLE_CYCLES-th edge after
//    the vector changes.
//   REPORT: res_valid=1; all res_* stable until res_valid&res_ready. On transfer:
//    vec==15 -> DONE, else vec++, cnt=0, go SETTLE. res_valid drops the cycle after transfer.
//   DONE: done=1 for one cycle; pass=(err_count==0); next state IDLE.
//  Throughput with res_ready held high: SETTLE_CYCLES+1 cycles per vector.
//  a..d keep the last vector after DONE/abort until the next start.
//  start while busy: ignored. start & abort together in IDLE: abort wins, stay IDLE.
//  abort in SETTLE/REPORT/DONE: next state IDLE, res_valid=0, no done pulse, pass=0.
//   err_count and fail_mask keep their partial values.
//  No wrap: vec never increments past 15. err_count saturates structurally at 16.
// TESTING
//  1. Correct DUTs, SETTLE_CYCLES=2, res_ready=1, start pulse -> 16 records with res_err=0;
//     done high 48 cycles after the start edge; pass=1, err_count=0, fail_mask=16'h0000.
//  2. h stuck-at-0 -> err_count=11, fail_mask=16'hAEEE, pass=0, done pulses once.
//  3. res_ready low for 5 cycles at vec=3 -> res_valid and res_* held (res_vec=4'h3);
//     a..d stay 4'b0011; sweep resumes at vec=4 after accept.
//  4. abort at vec=7 in SETTLE -> IDLE next cycle, busy=0, no done, pass=0;
//     a fresh start restarts at vec=0 with err_count cleared.
//  5. rst asserted mid-REPORT -> all outputs at reset values next cycle;
//     start while busy -> no effect on vec or counters.
//  6. f inverted -> err_count=16, fail_mask=16'hFFFF.
//     Exhaustive res_exp check vs golden equations for all 16 vectors.

Source files
------------

// File: rtl/logic_sweep_ctrl.sv
// rtl/logic_sweep_ctrl.sv - exhaustive 4-input sweep sequencer with golden compare and result log port
module logic_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    input  logic        g,
    input  logic        h,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_vec,
    output logic [2:0]  res_got,
    output logic [2:0]  res_exp,
    output logic        res_err,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] fail_mask
);

    // Counter value on which the held vector has settled long enough to sample.
    localparam logic [7:0] SAMPLE_AT = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_REPORT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  res_vec_q, res_vec_d;
    logic [2:0]  res_got_q, res_got_d;
    logic [2:0]  res_exp_q, res_exp_d;
    logic        res_err_q, res_err_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_count_q, err_count_d;
    logic [15:0] fail_mask_q, fail_mask_d;

    logic [2:0]  golden;
    logic [2:0]  sampled;
    logic        sample_now;
    logic        last_vec;

    // Golden reference for the vector currently on a..d.
    always_comb begin
        golden[2] = vec_q[3] ^ vec_q[2];
        golden[1] = (vec_q[3] & vec_q[2]) | (vec_q[3] & vec_q[1]) | (vec_q[2] & ~vec_q[1]);
        golden[0] = vec_q[0] | (vec_q[1] & ~(vec_q[3] & vec_q[2]));
    end

    assign sampled    = {f, g, h};
    assign sample_now = (state_q == S_SETTLE) && (cnt_q == SAMPLE_AT) && !abort;
    assign last_vec   = (vec_q == 4'hF);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SAMPLE_AT) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (res_ready) begin
                    state_d = last_vec ? S_DONE : S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; an abort in DONE suppresses the done pulse.
    always_comb begin
        busy      = (state_q != S_IDLE);
        res_valid = (state_q == S_REPORT);
        done      = (state_q == S_DONE) && !abort;
    end

    // Datapath next-state: vector stepping, settle count, capture and error bookkeeping.
    always_comb begin
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        res_vec_d   = res_vec_q;
        res_got_d   = res_got_q;
        res_exp_d   = res_exp_q;
        res_err_d   = res_err_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_mask_d = fail_mask_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    vec_d       = 4'h0;
                    cnt_d       = 8'd0;
                    err_count_d = 5'd0;
                    fail_mask_d = 16'h0000;
                    pass_d      = 1'b0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    pass_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (sample_now) begin
                    res_vec_d = vec_q;
                    res_got_d = sampled;
                    res_exp_d = golden;
                    res_err_d = (sampled != golden);
                    if (sampled != golden) begin
                        err_count_d        = err_count_q + 5'd1;
                        fail_mask_d[vec_q] = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                if (abort) begin
                    pass_d = 1'b0;
                end else if (res_ready && !last_vec) begin
                    vec_d = vec_q + 4'h1;
                    cnt_d = 8'd0;
                end
            end
            S_DONE: begin
                pass_d = abort ? 1'b0 : (err_count_q == 5'd0);
            end
            default: begin
                pass_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset discards any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q       <= 4'h0;
            cnt_q       <= 8'd0;
            res_vec_q   <= 4'h0;
            res_got_q   <= 3'b000;
            res_exp_q   <= 3'b000;
            res_err_q   <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 5'd0;
            fail_mask_q <= 16'h0000;
        end else begin
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            res_vec_q   <= res_vec_d;
            res_got_q   <= res_got_d;
            res_exp_q   <= res_exp_d;
            res_err_q   <= res_err_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign {a, b, c, d} = vec_q;
    assign res_vec      = res_vec_q;
    assign res_got      = res_got_q;
    assign res_exp      = res_exp_q;
    assign res_err      = res_err_q;
    assign pass         = pass_q;
    assign err_count    = err_count_q;
    assign fail_mask    = fail_mask_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// tb/tb_logic_sweep_ctrl.sv - scoreboard bench for logic_sweep_ctrl
module tb_logic_sweep_ctrl;

    // Truth tables of the golden functions, bit i = value for vec i = {a,b,c,d}.
    localparam logic [15:0] F_TT = 16'h0FF0;
    localparam logic [15:0] G_TT = 16'hFC30;
    localparam logic [15:0] H_TT = 16'hAEEE;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic        a, b, c, d;
    logic        f, g, h;
    logic        res_valid, res_ready;
    logic [3:0]  res_vec;
    logic [2:0]  res_got, res_exp;
    logic        res_err, busy, done, pass;
    logic [4:0]  err_count;
    logic [15:0] fail_mask;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int fault_mode = 0;   // 0 correct, 1 h stuck-at-0, 2 f inverted

    typedef struct {
        logic [3:0] vec;
        logic [2:0] got;
        logic [2:0] exp;
    } rec_t;
    rec_t sb_q[$];
    rec_t mon_r;

    always #5 clk = ~clk;

    logic_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a(a), .b(b), .c(c), .d(d), .f(f), .g(g), .h(h),
        .res_valid(res_valid), .res_ready(res_ready), .res_vec(res_vec),
        .res_got(res_got), .res_exp(res_exp), .res_err(res_err),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask)
    );

    function automatic logic [2:0] dut_model(input logic [3:0] v, input int fm);
        logic va, vb, vc, vd, mf, mg, mh;
        {va, vb, vc, vd} = v;
        mf = va ^ vb;
        mg = (va & vb) | (va & vc) | (vb & ~vc);
        mh = vd | (vc & ~(va & vb));
        if (fm == 2) mf = ~mf;
        if (fm == 1) mh = 1'b0;
        return {mf, mg, mh};
    endfunction

    function automatic logic [2:0] golden_tt(input logic [3:0] v);
        return {F_TT[v], G_TT[v], H_TT[v]};
    endfunction

    function automatic int count_err(input int upto, input int fm);
        int n = 0;
        for (int v = 0; v < upto; v++)
            if (dut_model(4'(v), fm) != golden_tt(4'(v))) n++;
        return n;
    endfunction

    function automatic logic [15:0] calc_mask(input int upto, input int fm);
        logic [15:0] m = 16'h0000;
        for (int v = 0; v < upto; v++)
            if (dut_model(4'(v), fm) != golden_tt(4'(v))) m[v] = 1'b1;
        return m;
    endfunction

    always_comb {f, g, h} = dut_model({a, b, c, d}, fault_mode);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: one record pops per accepted transfer.
    always @(negedge clk) begin
        if (rst === 1'b0 && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_r = sb_q.pop_front();
                check_val("res_vec", 32'(res_vec), 32'(mon_r.vec));
                check_val("res_got", 32'(res_got), 32'(mon_r.got));
                check_val("res_exp", 32'(res_exp), 32'(mon_r.exp));
                check_val("res_err", 32'(res_err), 32'(mon_r.got != mon_r.exp));
                check_val("abcd_in_report", 32'({a, b, c, d}), 32'(mon_r.vec));
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        rec_t r;
        sb_q.delete();
        for (int v = 0; v < 16; v++) begin
            r.vec = 4'(v);
            r.got = dut_model(4'(v), fault_mode);
            r.exp = golden_tt(4'(v));
            sb_q.push_back(r);
        end
    endtask

    task automatic start_sweep();
        push_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
        if (!done) check_val("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_vec(input logic [3:0] v, input logic want_valid);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if ({a, b, c, d} == v && res_valid == want_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_val("wait_vec_timeout", 32'({a, b, c, d}), 32'(v));
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_abcd"}, 32'({a, b, c, d}), 32'd0);
        check_val({tag, "_res"}, 32'({res_valid, res_vec, res_got, res_exp, res_err}), 32'd0);
        check_val({tag, "_busy_done_pass"}, 32'({busy, done, pass}), 32'd0);
        check_val({tag, "_err_count"}, 32'(err_count), 32'd0);
        check_val({tag, "_fail_mask"}, 32'(fail_mask), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [13:0] held;
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Clean sweep: timing, pass and record stream.
        fault_mode = 0;
        done_cnt = 0;
        start_sweep();
        check_val("busy_after_start", 32'(busy), 32'd1);
        wait_done(n);
        check_val("done_latency", 32'(n), 32'd48);
        check_val("clean_err_count", 32'(err_count), 32'd0);
        check_val("clean_fail_mask", 32'(fail_mask), 32'h0000);
        tick();
        check_val("clean_pass", 32'(pass), 32'd1);
        check_val("clean_idle", 32'({busy, done}), 32'd0);
        check_val("clean_done_cnt", 32'(done_cnt), 32'd1);
        check_val("clean_sb_empty", 32'(sb_q.size()), 32'd0);
        check_val("abcd_hold_after_done", 32'({a, b, c, d}), 32'hF);

        // Back-pressure at vec 3.
        start_sweep();
        wait_vec(4'h3, 1'b0);
        res_ready = 1'b0;
        wait_vec(4'h3, 1'b1);
        held = {res_vec, res_got, res_exp, res_err, {a, b, c, d}};
        repeat (5) begin
            tick();
            check_val("stall_valid", 32'(res_valid), 32'd1);
            check_val("stall_res_vec", 32'(res_vec), 32'h3);
            check_val("stall_abcd", 32'({a, b, c, d}), 32'h3);
            check_val("stall_held", 32'({res_vec, res_got, res_exp, res_err, {a, b, c, d}}), 32'(held));
        end
        res_ready = 1'b1;
        tick();
        check_val("resume_abcd", 32'({a, b, c, d}), 32'h4);
        check_val("resume_valid_drop", 32'(res_valid), 32'd0);
        wait_done(n);
        tick();
        check_val("stall_pass", 32'(pass), 32'd1);

        // Abort at vec 7 with h stuck-at-0, then a full faulty sweep.
        fault_mode = 1;
        done_cnt = 0;
        start_sweep();
        wait_vec(4'h7, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_valid", 32'(res_valid), 32'd0);
        check_val("abort_pass", 32'(pass), 32'd0);
        check_val("abort_abcd", 32'({a, b, c, d}), 32'h7);
        check_val("abort_err_count", 32'(err_count), 32'(count_err(7, 1)));
        check_val("abort_fail_mask", 32'(fail_mask), 32'(calc_mask(7, 1)));
        repeat (3) tick();
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        start_sweep();
        check_val("restart_abcd", 32'({a, b, c, d}), 32'h0);
        check_val("restart_err_cleared", 32'({err_count, fail_mask}), 32'd0);
        wait_done(n);
        check_val("hstuck_err_count", 32'(err_count), 32'(count_err(16, 1)));
        check_val("hstuck_err_count_const", 32'(err_count), 32'd11);
        check_val("hstuck_fail_mask", 32'(fail_mask), 32'hAEEE);
        tick();
        check_val("hstuck_pass", 32'(pass), 32'd0);
        check_val("hstuck_done_once", 32'(done_cnt), 32'd1);
        check_val("hstuck_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in REPORT, then start while busy.
        fault_mode = 0;
        start_sweep();
        wait_vec(4'h5, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        sb_q.delete();
        start_sweep();
        wait_vec(4'h2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_busy_abcd", 32'({a, b, c, d}), 32'h2);
        check_val("start_busy_busy", 32'(busy), 32'd1);
        wait_done(n);
        check_val("start_busy_err", 32'(err_count), 32'd0);
        tick();
        check_val("start_busy_pass", 32'(pass), 32'd1);

        // f inverted: every vector fails.
        fault_mode = 2;
        start_sweep();
        wait_done(n);
        check_val("finv_err_count", 32'(err_count), 32'd16);
        check_val("finv_fail_mask", 32'(fail_mask), 32'hFFFF);
        tick();
        check_val("finv_pass", 32'(pass), 32'd0);
        check_val("finv_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
